control_signal_encoder: RTL and testbench
=========================================

// Module: control_signal_encoder
// PURPOSE
//   Generates the 4-bit control_signal word consumed by decode_signal. Accepts mode requests over a
//   valid/ready handshake and drives only legal codes. Lock is sticky until reset. A programmable hold
//   time keeps each new code stable before the next change. Sits in the control/config domain, driving
//   decode_signal directly.
// PARAMETERS
//   HOLD_CYCLES  4                            min cycles a newly issued code is held; 0 = no hold
//   CNT_W        $clog2(HOLD_CYCLES+1) (>=1)  hold counter width (derived, do not override)
// PORTS
//   clk             in   1  clock; all state on rising edge
//   rst             in   1  asynchronous, active-high reset
//   req_valid       in   1  mode request valid
//   req_ready       out  1  block can accept a request this cycle
//   req_mode        in   2  00=IDLE, 01=ENABLE, 10=LOCK, 11=illegal
//   control_signal  out  4  registered code: IDLE=4'b0010, ENABLE=4'b0001, LOCK=4'b0011
//   locked          out  1  high while in LOCK state
//   err_illegal     out  1  1-cycle pulse: accepted request had req_mode=11
//   err_locked      out  1  1-cycle pulse: accepted request tried to leave LOCK
// BEHAVIOUR
//   Reset (async assert, sync release): state=ST_IDLE; control_signal=4'b0010; locked=0;
//     err_*=0; hold cnt=0, so req_ready=1.
//   Handshake: accept when req_valid & req_ready at edge N. req_ready = (cnt==0), independent of req_valid.
//   FSM (one-hot or binary, encoding free): ST_IDLE, ST_ENABLE, ST_LOCK.
//     ST_IDLE   : 01->ST_ENABLE, 10->ST_LOCK, 00->stay (no-op), 11->stay + err_illegal
//     ST_ENABLE : 00->ST_IDLE,   10->ST_LOCK, 01->stay (no-op), 11->stay + err_illegal
//     ST_LOCK   : 10->stay (no-op, no error); 00/01->stay + err_locked; 11->stay + err_illegal
//     Only rst leaves ST_LOCK.
//   Output: control_signal is registered from next state, updating at edge N+1 (1-cycle latency).
//     It never carries any value except the three legal codes, including during reset.
//   Hold: on an accepted request that changes state, cnt<=HOLD_CYCLES at N+1. While cnt!=0,
//     cnt decrements each cycle. req_ready is low for exactly HOLD_CYCLES cycles, N+1..N+HOLD_CYCLES.
//   No-op and error requests do not load cnt; back-to-back accepts are allowed.
//   Errors: err_illegal and err_locked are registered and high only at N+1; they are never
//     simultaneous. A change and an error never occur on the same accept.
//   HOLD_CYCLES=0: req_ready is tied high, and one state change per cycle is allowed.
//   Reset mid-hold: cnt clears and the state returns to ST_IDLE immediately (async). Pending
//     error pulses are cleared.
//   req_valid while req_ready=0: ignored, no side effects. The requester must hold the request.
//   locked == (control_signal==4'b0011) at all times.
// STRUCTURE
//   ctrl_sig_pkg: localparams CODE_IDLE/CODE_ENABLE/CODE_LOCK (4-bit), req_mode_t enum
//     (MODE_IDLE/ENABLE/LOCK/ILLEGAL), ctrl_state_t enum. The package is shared with decode_signal tests.
//   Sub-module ctrl_hold_timer: load/HOLD_CYCLES countdown, exposes busy (=cnt!=0).
//   The top holds the FSM, output registers and error pulse logic.
// TESTING (HOLD_CYCLES=4 unless noted)
//   1. Release reset -> control_signal=4'b0010, locked=0, req_ready=1, no err pulses.
//   2. Accept ENABLE at N -> control_signal=4'b0001 at N+1; req_ready=0 N+1..N+4, 1 at N+5.
//      An IDLE request at N+2 is held and accepted at N+5 -> control_signal=4'b0010 at N+6.
//   3. ENABLE then LOCK -> 4'b0011, locked=1. Then IDLE and ENABLE requests -> err_locked pulse
//      each, code unchanged. A LOCK request -> no pulse. Assert rst -> 4'b0010 immediately.
//   4. req_mode=11 in each state -> err_illegal for 1 cycle, code and req_ready unchanged.
//   5. Assert rst at N+2 during a hold -> req_ready=1, control_signal=4'b0010 asynchronously.
//   6. HOLD_CYCLES=0: alternate ENABLE/IDLE every cycle -> control_signal toggles each cycle,
//      req_ready constantly 1. Decode via decode_signal each cycle: outputs always match the mode.

Source files
------------

// File: rtl/control_signal_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_sig_pkg
//  Description : Shared definitions for the control_signal encoder and its
//                consumers: the three legal 4-bit control codes, the request
//                mode encoding and the encoder state type. decode_signal
//                tests import this package too, so codes live here only.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_sig_pkg;

    localparam logic [3:0] CODE_IDLE   = 4'b0010;
    localparam logic [3:0] CODE_ENABLE = 4'b0001;
    localparam logic [3:0] CODE_LOCK   = 4'b0011;

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'b00,
        MODE_ENABLE  = 2'b01,
        MODE_LOCK    = 2'b10,
        MODE_ILLEGAL = 2'b11
    } req_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENABLE = 2'd1,
        ST_LOCK   = 2'd2
    } ctrl_state_t;

    // Every state maps to a legal code; the unused encoding falls back to
    // IDLE so the output word can never carry anything else.
    function automatic logic [3:0] state_code(input ctrl_state_t s);
        logic [3:0] code;
        case (s)
            ST_ENABLE: code = CODE_ENABLE;
            ST_LOCK:   code = CODE_LOCK;
            default:   code = CODE_IDLE;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_signal_encoder_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_hold_timer
//  Description : Hold-time countdown. A load pulse sets the counter to
//                HOLD_CYCLES; it then counts down to zero, one per cycle.
//                busy is high while the counter is non-zero.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset (clears the counter)
//                load - start a new hold window
//                busy - hold window in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_hold_timer #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_load_val = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // With HOLD_CYCLES=0 the load value is zero, so the counter is constant
    // zero and busy reduces to a tie-low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/control_signal_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : control_signal_encoder
//  Description : Drives the 4-bit control_signal word for decode_signal.
//                Mode requests arrive over valid/ready; only legal codes are
//                ever output. LOCK is sticky until reset. After every state
//                change the request port is closed for HOLD_CYCLES cycles.
//  Ports       : clk            - clock
//                rst            - asynchronous active-high reset
//                req_valid      - mode request valid
//                req_ready      - request can be accepted this cycle
//                req_mode       - 00 IDLE, 01 ENABLE, 10 LOCK, 11 illegal
//                control_signal - registered legal code
//                locked         - control_signal is the LOCK code
//                err_illegal    - 1-cycle pulse, accepted mode 11
//                err_locked     - 1-cycle pulse, accepted attempt to leave LOCK
//  Revision    : 1.0 - initial release
// ============================================================================
module control_signal_encoder
    import ctrl_sig_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_mode,
    output logic [3:0] control_signal,
    output logic       locked,
    output logic       err_illegal,
    output logic       err_locked
);

    ctrl_state_t r_state;
    ctrl_state_t w_next_state;
    logic [3:0]  r_code;
    logic        r_err_illegal;
    logic        r_err_locked;
    logic        w_err_illegal;
    logic        w_err_locked;
    logic        w_accept;
    logic        w_busy;
    logic        w_load;

    assign req_ready = ~w_busy;
    assign w_accept  = req_valid & req_ready;

    // Only a real state change opens a hold window; no-op and error
    // requests leave the port open for back-to-back accepts.
    assign w_load = w_accept & (w_next_state != r_state);

    ctrl_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .busy (w_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_err_illegal = 1'b0;
        w_err_locked  = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    case (req_mode_t'(req_mode))
                        MODE_ENABLE:  w_next_state  = ST_ENABLE;
                        MODE_LOCK:    w_next_state  = ST_LOCK;
                        MODE_ILLEGAL: w_err_illegal = 1'b1;
                        default:      w_next_state  = ST_IDLE;
                    endcase
                end
                ST_ENABLE: begin
                    case (req_mode_t'(req_mode))
                        MODE_IDLE:    w_next_state  = ST_IDLE;
                        MODE_LOCK:    w_next_state  = ST_LOCK;
                        MODE_ILLEGAL: w_err_illegal = 1'b1;
                        default:      w_next_state  = ST_ENABLE;
                    endcase
                end
                ST_LOCK: begin
                    // Nothing but reset leaves LOCK; re-requesting LOCK is silent.
                    case (req_mode_t'(req_mode))
                        MODE_IDLE,
                        MODE_ENABLE:  w_err_locked  = 1'b1;
                        MODE_ILLEGAL: w_err_illegal = 1'b1;
                        default:      w_next_state  = ST_LOCK;
                    endcase
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Code is registered from the next state so it is a plain flop output
    // and tracks r_state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code        <= CODE_IDLE;
            r_err_illegal <= 1'b0;
            r_err_locked  <= 1'b0;
        end else begin
            r_code        <= state_code(w_next_state);
            r_err_illegal <= w_err_illegal;
            r_err_locked  <= w_err_locked;
        end
    end

    assign control_signal = r_code;
    assign locked         = (r_code == CODE_LOCK);
    assign err_illegal    = r_err_illegal;
    assign err_locked     = r_err_locked;

endmodule
`default_nettype wire

// File: tb/tb_control_signal_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_signal_encoder
//  Description : Directed bench for control_signal_encoder. Unit 0 uses
//                HOLD_CYCLES=4, unit 1 uses HOLD_CYCLES=0. Expected outputs
//                are queued when a request is driven and compared after the
//                following clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_signal_encoder;

    localparam logic [3:0] C_IDLE = 4'b0010;
    localparam logic [3:0] C_EN   = 4'b0001;
    localparam logic [3:0] C_LOCK = 4'b0011;
    localparam logic [1:0] M_ID   = 2'b00;
    localparam logic [1:0] M_EN   = 2'b01;
    localparam logic [1:0] M_LK   = 2'b10;
    localparam logic [1:0] M_IL   = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [1:0] m0 = 2'b00, m1 = 2'b00;
    logic       rdy0, rdy1, lck0, lck1, ei0, ei1, el0, el1;
    logic [3:0] code0, code1;

    typedef struct {
        int         unit;
        logic [3:0] code;
        logic       lck;
        logic       rdy;
        logic       ei;
        logic       el;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    control_signal_encoder #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_mode(m0),
        .control_signal(code0), .locked(lck0), .err_illegal(ei0), .err_locked(el0)
    );

    control_signal_encoder #(.HOLD_CYCLES(0)) dut_h0 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_mode(m1),
        .control_signal(code1), .locked(lck1), .err_illegal(ei1), .err_locked(el1)
    );

    function automatic logic [1:0] decode(input logic [3:0] c);
        case (c)
            C_IDLE:  return M_ID;
            C_EN:    return M_EN;
            C_LOCK:  return M_LK;
            default: return M_IL;
        endcase
    endfunction

    task automatic expect_out(input int unit, input logic [3:0] code, input logic rdy,
                              input logic ei, input logic el, input string tag);
        exp_t e;
        e.unit = unit; e.code = code; e.lck = (code == C_LOCK);
        e.rdy = rdy; e.ei = ei; e.el = el; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic [3:0] oc;
        logic ol, orr, oi, oe;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $error("FAIL scoreboard_empty observed=0 expected>0 entries");
        end else begin
            e = sb.pop_front();
            if (e.unit == 0) begin
                oc = code0; ol = lck0; orr = rdy0; oi = ei0; oe = el0;
            end else begin
                oc = code1; ol = lck1; orr = rdy1; oi = ei1; oe = el1;
            end
            n_cmp++;
            assert (oc === e.code) else begin n_bad++; $error("FAIL %s code observed=%b expected=%b", e.tag, oc, e.code); end
            n_cmp++;
            assert (ol === e.lck) else begin n_bad++; $error("FAIL %s locked observed=%b expected=%b", e.tag, ol, e.lck); end
            n_cmp++;
            assert (orr === e.rdy) else begin n_bad++; $error("FAIL %s req_ready observed=%b expected=%b", e.tag, orr, e.rdy); end
            n_cmp++;
            assert (oi === e.ei) else begin n_bad++; $error("FAIL %s err_illegal observed=%b expected=%b", e.tag, oi, e.ei); end
            n_cmp++;
            assert (oe === e.el) else begin n_bad++; $error("FAIL %s err_locked observed=%b expected=%b", e.tag, oe, e.el); end
        end
    endtask

    // Drive one cycle of request, then compare the outputs of the next cycle.
    task automatic step(input int unit, input logic v, input logic [1:0] m, input logic [3:0] code,
                        input logic rdy, input logic ei, input logic el, input string tag);
        @(negedge clk);
        if (unit == 0) begin v0 = v; m0 = m; end
        else           begin v1 = v; m1 = m; end
        expect_out(unit, code, rdy, ei, el, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Four quiet cycles covering one full hold window on unit 0.
    task automatic hold_wait(input logic [3:0] code, input string tag);
        for (int i = 0; i < 4; i++)
            step(0, 1'b0, M_ID, code, (i == 3), 1'b0, 1'b0, tag);
    endtask

    // Assert reset mid-cycle and check both units without a clock edge.
    task automatic async_reset(input string tag);
        v0 = 1'b0; v1 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        expect_out(0, C_IDLE, 1'b1, 1'b0, 1'b0, tag);
        check_out();
        expect_out(1, C_IDLE, 1'b1, 1'b0, 1'b0, tag);
        check_out();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // 1. reset state
        repeat (2) @(posedge clk);
        #1;
        expect_out(0, C_IDLE, 1'b1, 1'b0, 1'b0, "reset_u0"); check_out();
        expect_out(1, C_IDLE, 1'b1, 1'b0, 1'b0, "reset_u1"); check_out();
        @(negedge clk);
        rst = 1'b0;
        step(0, 1'b0, M_ID, C_IDLE, 1'b1, 1'b0, 1'b0, "post_reset");

        // 2. ENABLE, then IDLE held through the hold window
        step(0, 1'b1, M_EN, C_EN,   1'b0, 1'b0, 1'b0, "t2_enable");
        step(0, 1'b1, M_ID, C_EN,   1'b0, 1'b0, 1'b0, "t2_held_n2");
        step(0, 1'b1, M_ID, C_EN,   1'b0, 1'b0, 1'b0, "t2_held_n3");
        step(0, 1'b1, M_ID, C_EN,   1'b0, 1'b0, 1'b0, "t2_held_n4");
        step(0, 1'b1, M_ID, C_EN,   1'b1, 1'b0, 1'b0, "t2_ready_n5");
        step(0, 1'b1, M_ID, C_IDLE, 1'b0, 1'b0, 1'b0, "t2_idle_n6");
        hold_wait(C_IDLE, "t2_hold");

        // 3. LOCK is sticky; leaving it raises err_locked
        step(0, 1'b1, M_EN, C_EN,   1'b0, 1'b0, 1'b0, "t3_enable");
        hold_wait(C_EN, "t3_hold_en");
        step(0, 1'b1, M_LK, C_LOCK, 1'b0, 1'b0, 1'b0, "t3_lock");
        hold_wait(C_LOCK, "t3_hold_lk");
        step(0, 1'b1, M_ID, C_LOCK, 1'b1, 1'b0, 1'b1, "t3_lock_idle_err");
        step(0, 1'b1, M_EN, C_LOCK, 1'b1, 1'b0, 1'b1, "t3_lock_en_err");
        step(0, 1'b1, M_LK, C_LOCK, 1'b1, 1'b0, 1'b0, "t3_lock_lock_quiet");
        step(0, 1'b1, M_IL, C_LOCK, 1'b1, 1'b1, 1'b0, "t4_illegal_lock");
        async_reset("t3_reset_clears_lock_and_pulse");

        // 4. illegal mode in IDLE and ENABLE
        step(0, 1'b1, M_IL, C_IDLE, 1'b1, 1'b1, 1'b0, "t4_illegal_idle");
        step(0, 1'b0, M_ID, C_IDLE, 1'b1, 1'b0, 1'b0, "t4_pulse_end_idle");
        step(0, 1'b1, M_EN, C_EN,   1'b0, 1'b0, 1'b0, "t4_enable");
        hold_wait(C_EN, "t4_hold_en");
        step(0, 1'b1, M_IL, C_EN,   1'b1, 1'b1, 1'b0, "t4_illegal_enable");
        step(0, 1'b0, M_ID, C_EN,   1'b1, 1'b0, 1'b0, "t4_pulse_end_en");

        // 5. reset in the middle of a hold window
        step(0, 1'b1, M_LK, C_LOCK, 1'b0, 1'b0, 1'b0, "t5_lock_n1");
        step(0, 1'b0, M_ID, C_LOCK, 1'b0, 1'b0, 1'b0, "t5_hold_n2");
        async_reset("t5_reset_mid_hold");
        step(0, 1'b0, M_ID, C_IDLE, 1'b1, 1'b0, 1'b0, "t5_after_reset");

        // 6. HOLD_CYCLES=0: one change per cycle, decoded word follows the mode
        for (int i = 0; i < 8; i++) begin
            step(1, 1'b1, (i % 2 == 0) ? M_EN : M_ID, (i % 2 == 0) ? C_EN : C_IDLE,
                 1'b1, 1'b0, 1'b0, "t6_toggle");
            n_cmp++;
            assert (decode(code1) === m1) else begin
                n_bad++;
                $error("FAIL t6_decode observed=%b expected=%b", decode(code1), m1);
            end
        end
        step(1, 1'b0, M_ID, C_IDLE, 1'b1, 1'b0, 1'b0, "t6_quiet");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
